// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared fetch-stage constants, next-PC select codes and helpers
package instr_fetch_pkg;

    localparam int          WORD_BYTES     = 4;
    localparam int          DEF_IMEM_WORDS = 100;
    localparam logic [31:0] DEF_RESET_ADDR = 32'd0;
    localparam logic [31:0] DEF_ILLOP_ADDR = 32'd4;
    localparam logic [31:0] DEF_XADR_ADDR  = 32'd8;
    localparam logic [31:0] NOP_INSTR      = 32'h83FF_F800;

    localparam logic [5:0]  OP_ADD  = 6'h20;
    localparam logic [5:0]  OP_BEQ  = 6'h1C;
    localparam logic [5:0]  OP_BNE  = 6'h1D;
    localparam logic [5:0]  OP_JMP  = 6'h1B;
    localparam logic [5:0]  OP_LD   = 6'h18;
    localparam logic [5:0]  OP_ST   = 6'h19;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_ADV,
        SEL_REDIR,
        SEL_IRQ,
        SEL_FAULT,
        SEL_ILLOP
    } fetch_sel_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic is_trap(input fetch_sel_e s);
        return (s == SEL_ILLOP) || (s == SEL_FAULT) || (s == SEL_IRQ);
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, single-entry IR with valid/ready, redirect and trap vectoring
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEF_RESET_ADDR,
    parameter logic [31:0] ILLOP_ADDR = DEF_ILLOP_ADDR,
    parameter logic [31:0] XADR_ADDR  = DEF_XADR_ADDR,
    parameter int          IMEM_WORDS = DEF_IMEM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_instr,
    output logic [31:0] o_out_pc,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_addr,
    input  logic        i_illop,
    input  logic        i_irq,
    output logic        o_trap_valid,
    output logic [31:0] o_trap_ret_addr
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * WORD_BYTES);

    if (IMEM_LIMIT <= ILLOP_ADDR) begin : g_bad_cfg
        $error("instr_fetch: ILLOP_ADDR lies outside instruction memory");
    end

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_out_pc;
    logic        r_valid;
    logic        r_trap;
    logic [31:0] r_ret;

    logic        w_advance;
    logic        w_fault;
    fetch_sel_e  w_sel;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_ret;

    always_comb begin
        w_advance = !r_valid || i_out_ready;
        w_fault   = r_pc >= IMEM_LIMIT;
        w_sel     = (i_illop && r_valid)    ? SEL_ILLOP :
                    w_fault                 ? SEL_FAULT :
                    (i_irq && w_advance)    ? SEL_IRQ   :
                    i_redirect_valid        ? SEL_REDIR :
                    w_advance               ? SEL_ADV   : SEL_HOLD;
        w_pc_nxt  = (w_sel == SEL_ILLOP || w_sel == SEL_FAULT) ? ILLOP_ADDR :
                    (w_sel == SEL_IRQ)                         ? XADR_ADDR  :
                    (w_sel == SEL_REDIR)                       ? word_align(i_redirect_addr) :
                    (w_sel == SEL_ADV)                         ? r_pc + 32'(WORD_BYTES) : r_pc;
        // an illegal op returns past the offending IR word, other traps past the PC
        w_ret     = (w_sel == SEL_ILLOP) ? r_out_pc + 32'(WORD_BYTES) : r_pc + 32'(WORD_BYTES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_ADDR;
            r_instr  <= '0;
            r_out_pc <= '0;
            r_valid  <= 1'b0;
            r_trap   <= 1'b0;
            r_ret    <= '0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_trap  <= is_trap(w_sel);
            r_valid <= (w_sel == SEL_ADV) ? 1'b1 : (w_sel == SEL_HOLD) ? r_valid : 1'b0;
            if (is_trap(w_sel))
                r_ret <= w_ret;
            if (w_sel == SEL_ADV) begin
                r_instr  <= i_imem_data;
                r_out_pc <= r_pc;
            end
        end
    end

    assign o_imem_addr     = r_pc;
    assign o_out_valid     = r_valid;
    assign o_out_instr     = r_instr;
    assign o_out_pc        = r_out_pc;
    assign o_trap_valid    = r_trap;
    assign o_trap_ret_addr = r_ret;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random fetch scenarios against a rule-level reference model
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_data;
    logic        o_out_valid;
    logic        i_out_ready = 1'b0;
    logic [31:0] o_out_instr;
    logic [31:0] o_out_pc;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_addr = '0;
    logic        i_illop = 1'b0;
    logic        i_irq = 1'b0;
    logic        o_trap_valid;
    logic [31:0] o_trap_ret_addr;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:127];

    logic [31:0] m_pc, m_instr, m_opc, m_ret;
    logic        m_valid, m_trap;

    always #5 clk = ~clk;

    assign i_imem_data = (o_imem_addr < 32'd400) ? mem[o_imem_addr[8:2]] : 32'hDEAD_BEEF;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .o_imem_addr(o_imem_addr), .i_imem_data(i_imem_data),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_instr(o_out_instr), .o_out_pc(o_out_pc),
        .i_redirect_valid(i_redirect_valid), .i_redirect_addr(i_redirect_addr),
        .i_illop(i_illop), .i_irq(i_irq),
        .o_trap_valid(o_trap_valid), .o_trap_ret_addr(o_trap_ret_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_opc = 0; m_ret = 0; m_valid = 0; m_trap = 0;
    endtask

    task automatic check_all();
        chk("imem_addr", o_imem_addr, m_pc);
        chk("out_valid", 32'(o_out_valid), 32'(m_valid));
        chk("trap_valid", 32'(o_trap_valid), 32'(m_trap));
        chk("out_instr", o_out_instr, m_instr);
        chk("out_pc", o_out_pc, m_opc);
        chk("trap_ret", o_trap_ret_addr, m_ret);
    endtask

    // one clock edge: apply the priority rules to the model, then compare
    task automatic tick();
        logic adv;
        @(posedge clk);
        adv = !m_valid || i_out_ready;
        if (i_illop && m_valid) begin
            m_trap = 1; m_ret = m_opc + 4; m_pc = 4; m_valid = 0;
        end else if (m_pc >= 400) begin
            m_trap = 1; m_ret = m_pc + 4; m_pc = 4; m_valid = 0;
        end else if (i_irq && adv) begin
            m_trap = 1; m_ret = m_pc + 4; m_pc = 8; m_valid = 0;
        end else begin
            m_trap = 0;
            if (i_redirect_valid) begin
                m_pc = i_redirect_addr & 32'hFFFF_FFFC; m_valid = 0;
            end else if (adv) begin
                m_instr = mem[m_pc[8:2]]; m_opc = m_pc; m_pc = m_pc + 4; m_valid = 1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic jump_to(input logic [31:0] a);
        i_redirect_valid = 1; i_redirect_addr = a;
        tick();
        i_redirect_valid = 0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        model_reset();
        #2;
        chk("rst_imem_addr", o_imem_addr, 32'd0);
        chk("rst_valid", 32'(o_out_valid), 32'd0);
        chk("rst_trap", 32'(o_trap_valid), 32'd0);
        @(negedge clk);
        rst_n = 1;
        i_out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("seq_pc", o_out_pc, 32'(k * 4));
            chk("seq_valid", 32'(o_out_valid), 32'd1);
        end
        jump_to(32'd4);
        tick(); tick();
        chk("pre_stall_pc", o_out_pc, 32'd8);
        i_out_ready = 0;
        repeat (3) begin
            tick();
            chk("stall_pc", o_out_pc, 32'd8);
            chk("stall_addr", o_imem_addr, 32'd12);
        end
        i_out_ready = 1;
        tick();
        chk("resume_pc", o_out_pc, 32'd12);
        tick();
        chk("pre_redir_pc", o_out_pc, 32'd16);
        jump_to(32'd83);
        chk("redir_flush", 32'(o_out_valid), 32'd0);
        tick();
        chk("redir_target", o_out_pc, 32'd80);
        jump_to(32'd24);
        tick();
        chk("illop_at", o_out_pc, 32'd24);
        i_illop = 1; i_out_ready = 0;
        tick();
        i_illop = 0; i_out_ready = 1;
        chk("illop_trap", 32'(o_trap_valid), 32'd1);
        chk("illop_ret", o_trap_ret_addr, 32'd28);
        tick();
        chk("illop_vec", o_out_pc, 32'd4);
        chk("trap_pulse", 32'(o_trap_valid), 32'd0);
        jump_to(32'd380);
        n = 0;
        while (!m_trap && n < 20) begin tick(); n++; end
        chk("fault_seen", 32'(o_trap_valid), 32'd1);
        chk("fault_ret", o_trap_ret_addr, 32'd404);
        chk("fault_last", o_out_pc, 32'd396);
        tick();
        chk("fault_vec", o_out_pc, 32'd4);
        jump_to(32'd36);
        tick();
        chk("irq_setup", o_imem_addr, 32'd40);
        i_out_ready = 0; i_irq = 1;
        repeat (3) begin
            tick();
            chk("irq_wait", 32'(o_trap_valid), 32'd0);
        end
        i_out_ready = 1;
        tick();
        i_irq = 0;
        chk("irq_trap", 32'(o_trap_valid), 32'd1);
        chk("irq_ret", o_trap_ret_addr, 32'd44);
        tick();
        chk("irq_vec", o_out_pc, 32'd8);
        tick();
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("post_rst_pc", o_out_pc, 32'd0);
        for (int k = 0; k < 400; k++) begin
            i_out_ready      = ($urandom % 4) != 0;
            i_redirect_valid = ($urandom % 8) == 0;
            i_redirect_addr  = $urandom_range(0, 430);
            i_illop          = ($urandom % 10) == 0;
            i_irq            = ($urandom % 16) == 0;
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
